cmp_seq_resolver: RTL and testbench

CMP_SEQ_RESOLVER -- requirements
Module: cmp_seq_resolver

---
 rtl/cmp_pkg.sv | 22 ++
 rtl/cmp_beat_counter.sv | 35 +++
 rtl/cmp_seq_resolver.sv | 118 +++++++++++
 tb/tb_cmp_seq_resolver.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared FSM state type and 3-bit one-hot result encoding for the
// bit-serial comparator resolver.
package cmp_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

    // Non-one-hot beat flags resolve as "equal" so they never decide a word.
    function automatic logic [2:0] beat_res(input logic [2:0] flags);
        if (flags == RES_GT || flags == RES_EQ || flags == RES_LT) begin
            return flags;
        end
        return RES_EQ;
    endfunction

endpackage

// File: rtl/cmp_beat_counter.sv
// Beat counter for one word: clear, increment, terminal-count flag at WIDTH.
// Self-clears on terminal count so it never holds or wraps past WIDTH.
module cmp_beat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc_c
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // clr and inc together restart the count at 1.
    always_comb begin
        cnt_nxt = clr ? CW'(0) : cnt;
        if (inc) begin
            cnt_nxt = cnt_nxt + CW'(1);
        end
        tc_c = inc && (cnt_nxt == CW'(WIDTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= tc_c ? '0 : cnt_nxt;
        end
    end

endmodule

// File: rtl/cmp_seq_resolver.sv
// Resolves a MSB-first stream of per-bit gt/eq/lt beats into a single
// word-level comparison result, flagging protocol and encoding errors.
module cmp_seq_resolver
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_sof,
    input  logic in_gt,
    input  logic in_eq,
    input  logic in_lt,
    output logic out_valid,
    output logic out_gt,
    output logic out_eq,
    output logic out_lt,
    output logic busy,
    output logic err
);

    state_t     state;
    state_t     state_n;
    logic [2:0] acc;
    logic [2:0] acc_n;
    logic [2:0] res;
    logic [2:0] res_n;
    logic [2:0] flags;
    logic [2:0] bres;
    logic       bad;
    logic       ov_n;
    logic       err_n;
    logic       clr;
    logic       inc;
    logic       tc_c;

    assign flags = {in_gt, in_eq, in_lt};
    assign bres  = beat_res(flags);
    assign bad   = (bres != flags);

    // Any sof beat restarts the count; continuation beats count only mid-word.
    assign clr = in_valid && in_sof;
    assign inc = in_valid && (in_sof || (state == ACTIVE));

    cmp_beat_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (inc),
        .tc_c  (tc_c)
    );

    always_comb begin
        state_n = state;
        acc_n   = acc;
        res_n   = res;
        ov_n    = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_sof) begin
                        acc_n   = bres;
                        err_n   = bad;
                        state_n = ACTIVE;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (in_valid) begin
                    if (in_sof) begin
                        acc_n = bres;
                        err_n = 1'b1;
                    end else begin
                        err_n = bad;
                        if (acc == RES_EQ) begin
                            acc_n = bres;
                        end
                    end
                end
            end
        endcase
        // Terminal beat closes the word from either state (WIDTH=1 closes in IDLE).
        if (tc_c) begin
            state_n = IDLE;
            ov_n    = 1'b1;
            res_n   = acc_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= RES_EQ;
            res       <= RES_EQ;
            out_valid <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            res       <= res_n;
            out_valid <= ov_n;
            err       <= err_n;
            busy      <= (state_n == ACTIVE);
        end
    end

    assign out_gt = res[2];
    assign out_eq = res[1];
    assign out_lt = res[0];

endmodule

// File: tb/tb_cmp_seq_resolver.sv
// Bench for cmp_seq_resolver at WIDTH=4: table of beats with expected
// per-cycle outputs, plus a scoreboard of word results for random words.
module tb_cmp_seq_resolver;

    localparam int unsigned WIDTH = 4;
    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;
    localparam logic [2:0] NO = 3'b000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_sof = 1'b0;
    logic in_gt = 1'b0;
    logic in_eq = 1'b0;
    logic in_lt = 1'b0;
    logic out_valid, out_gt, out_eq, out_lt, busy, err;

    int vectors = 0;
    int miscompares = 0;
    logic [2:0] sb[$];

    typedef struct {
        logic       rstn;
        logic       v;
        logic       sof;
        logic [2:0] f;
        logic       ov;
        logic [2:0] res;
        logic       err;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    cmp_seq_resolver #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_gt     (in_gt),
        .in_eq     (in_eq),
        .in_lt     (in_lt),
        .out_valid (out_valid),
        .out_gt    (out_gt),
        .out_eq    (out_eq),
        .out_lt    (out_lt),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0d: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    // Scoreboard: every out_valid pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out_valid: got result %b, expected none", {out_gt, out_eq, out_lt});
            end else begin
                check("sb_result", 0, {out_gt, out_eq, out_lt}, sb.pop_front());
            end
        end
    end

    function automatic vec_t mk(input logic rstn, input logic v, input logic sof, input logic [2:0] f,
                                input logic ov, input logic [2:0] res, input logic e, input logic b);
        vec_t t;
        t.rstn = rstn; t.v = v; t.sof = sof; t.f = f;
        t.ov = ov; t.res = res; t.err = e; t.busy = b;
        return t;
    endfunction

    task automatic drive(input logic rstn, input logic v, input logic sof, input logic [2:0] f);
        @(negedge clk);
        rst_n = rstn;
        in_valid = v;
        in_sof = sof;
        {in_gt, in_eq, in_lt} = f;
    endtask

    task automatic apply(input vec_t t, input int idx);
        drive(t.rstn, t.v, t.sof, t.f);
        if (t.ov) sb.push_back(t.res);
        @(posedge clk);
        #1;
        check("out_valid", idx, 3'(out_valid), 3'(t.ov));
        check("err", idx, 3'(err), 3'(t.err));
        check("busy", idx, 3'(busy), 3'(t.busy));
        check("result", idx, {out_gt, out_eq, out_lt}, t.res);
    endtask

    function automatic logic [2:0] ref_beat(input logic [2:0] f);
        return (f == GT || f == EQ || f == LT) ? f : EQ;
    endfunction

    initial begin
        // rstn v sof flags | ov res err busy  (outputs after the edge)
        tbl.push_back(mk(0, 0, 0, NO, 0, EQ, 0, 0));
        tbl.push_back(mk(0, 1, 1, GT, 0, EQ, 0, 0));
        // A=1010 B=1001: eq,eq,gt,lt -> GT
        tbl.push_back(mk(1, 1, 1, EQ, 0, EQ, 0, 1));
        tbl.push_back(mk(1, 1, 0, EQ, 0, EQ, 0, 1));
        tbl.push_back(mk(1, 1, 0, GT, 0, EQ, 0, 1));
        tbl.push_back(mk(1, 1, 0, LT, 1, GT, 0, 0));
        // partial word killed by reset, then clean lt word, then strays
        tbl.push_back(mk(1, 1, 1, LT, 0, GT, 0, 1));
        tbl.push_back(mk(1, 1, 0, GT, 0, GT, 0, 1));
        tbl.push_back(mk(0, 1, 0, EQ, 0, EQ, 0, 0));
        tbl.push_back(mk(1, 0, 0, NO, 0, EQ, 0, 0));
        tbl.push_back(mk(1, 1, 1, LT, 0, EQ, 0, 1));
        tbl.push_back(mk(1, 1, 0, GT, 0, EQ, 0, 1));
        tbl.push_back(mk(1, 1, 0, GT, 0, EQ, 0, 1));
        tbl.push_back(mk(1, 1, 0, EQ, 1, LT, 0, 0));
        tbl.push_back(mk(1, 1, 0, EQ, 0, LT, 1, 0));
        tbl.push_back(mk(1, 1, 0, 3'b111, 0, LT, 1, 0));
        tbl.push_back(mk(1, 0, 0, NO, 0, LT, 0, 0));
        // A=B=0110 with gaps -> EQ, single pulse
        tbl.push_back(mk(1, 1, 1, EQ, 0, LT, 0, 1));
        tbl.push_back(mk(1, 0, 0, NO, 0, LT, 0, 1));
        tbl.push_back(mk(1, 1, 0, EQ, 0, LT, 0, 1));
        tbl.push_back(mk(1, 0, 0, NO, 0, LT, 0, 1));
        tbl.push_back(mk(1, 0, 0, NO, 0, LT, 0, 1));
        tbl.push_back(mk(1, 1, 0, EQ, 0, LT, 0, 1));
        tbl.push_back(mk(1, 1, 0, EQ, 1, EQ, 0, 0));
        tbl.push_back(mk(1, 0, 0, NO, 0, EQ, 0, 0));
        // sof on beat 3 aborts; restarted word lt,eq,gt,eq -> LT
        tbl.push_back(mk(1, 1, 1, GT, 0, EQ, 0, 1));
        tbl.push_back(mk(1, 1, 0, EQ, 0, EQ, 0, 1));
        tbl.push_back(mk(1, 1, 1, LT, 0, EQ, 1, 1));
        tbl.push_back(mk(1, 1, 0, EQ, 0, EQ, 0, 1));
        tbl.push_back(mk(1, 1, 0, GT, 0, EQ, 0, 1));
        tbl.push_back(mk(1, 1, 0, EQ, 1, LT, 0, 0));
        // bad beat gt=lt=1 then eq,lt,eq -> LT
        tbl.push_back(mk(1, 1, 1, 3'b101, 0, LT, 1, 1));
        tbl.push_back(mk(1, 1, 0, EQ, 0, LT, 0, 1));
        tbl.push_back(mk(1, 1, 0, LT, 0, LT, 0, 1));
        tbl.push_back(mk(1, 1, 0, EQ, 1, LT, 0, 0));
        // back-to-back: GT word, then word starting with a 000 beat -> EQ
        tbl.push_back(mk(1, 1, 1, GT, 0, LT, 0, 1));
        tbl.push_back(mk(1, 1, 0, EQ, 0, LT, 0, 1));
        tbl.push_back(mk(1, 1, 0, LT, 0, LT, 0, 1));
        tbl.push_back(mk(1, 1, 0, EQ, 1, GT, 0, 0));
        tbl.push_back(mk(1, 1, 1, NO, 0, GT, 1, 1));
        tbl.push_back(mk(1, 1, 0, EQ, 0, GT, 0, 1));
        tbl.push_back(mk(1, 1, 0, EQ, 0, GT, 0, 1));
        tbl.push_back(mk(1, 1, 0, EQ, 1, EQ, 0, 0));
        tbl.push_back(mk(1, 0, 0, NO, 0, EQ, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Random words with random gaps and encodings, checked via scoreboard.
        for (int w = 0; w < 20; w++) begin
            logic [2:0] acc;
            logic [2:0] f;
            int budget;
            acc = EQ;
            for (int b = 0; b < int'(WIDTH); b++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    drive(1'b1, 1'b0, 1'b0, NO);
                end
                f = 3'($urandom_range(0, 7));
                if (acc == EQ) acc = ref_beat(f);
                drive(1'b1, 1'b1, (b == 0), f);
                if (b == int'(WIDTH) - 1) sb.push_back(acc);
            end
            drive(1'b1, 1'b0, 1'b0, NO);
            budget = 5;
            while (sb.size() != 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (sb.size() != 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_timeout word %0d: got %0d pending results, expected 0", w, sb.size());
                sb.delete();
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 0, 3'(sb.size()), 3'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
